// File: rtl/tcm_data_arb.sv
// Two-requester arbiter for the TCM data port: round-robin between the core LSU (port 0)
// and the loader/DMA (port 1), with a port-1 burst lock bounded by a starvation limit.
module tcm_data_arb #(
  parameter int unsigned MEM_ADDR_WIDTH = 8,
  parameter int unsigned STARVE_LIMIT   = 8
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_p0_req,
  input  logic [(MEM_ADDR_WIDTH+1):2] i_p0_addr,
  input  logic                        i_p0_write,
  input  logic [3:0]                  i_p0_mask,
  input  logic [31:0]                 i_p0_data,
  output logic                        o_p0_gnt,
  output logic                        o_p0_rvalid,
  output logic [31:0]                 o_p0_data,
  input  logic                        i_p1_req,
  input  logic [(MEM_ADDR_WIDTH+1):2] i_p1_addr,
  input  logic                        i_p1_write,
  input  logic [3:0]                  i_p1_mask,
  input  logic [31:0]                 i_p1_data,
  output logic                        o_p1_gnt,
  output logic                        o_p1_rvalid,
  output logic [31:0]                 o_p1_data,
  input  logic                        i_p1_lock,
  output logic                        o_tcm_sel,
  output logic [(MEM_ADDR_WIDTH+1):2] o_tcm_addr,
  output logic                        o_tcm_write,
  output logic [3:0]                  o_tcm_mask,
  output logic [31:0]                 o_tcm_data,
  input  logic [31:0]                 i_tcm_data
);

  localparam int unsigned SW = 8;

  typedef enum logic {FREE = 1'b0, LOCKED = 1'b1} lock_state_t;

  lock_state_t   r_state;
  logic          r_last;
  logic [SW-1:0] r_starve;
  logic          r_rd_pend;
  logic          r_rd_port;

  logic p0_gnt;
  logic p1_gnt;
  logic starve_hit;
  logic lock_exit;

  // Same-cycle grant: locked port 1 wins outright, otherwise round-robin on contention.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!i_reset) begin
      if (r_state == LOCKED) begin
        p1_gnt = i_p1_req;
      end else if (i_p0_req && i_p1_req) begin
        p0_gnt = r_last;
        p1_gnt = ~r_last;
      end else begin
        p0_gnt = i_p0_req;
        p1_gnt = i_p1_req;
      end
    end
  end

  // The grant that brings the count up to the limit is the last one the lock may take.
  assign starve_hit = (r_state == LOCKED) && p1_gnt && i_p0_req &&
                      ((9'({1'b0, r_starve}) + 9'd1) == 9'(STARVE_LIMIT));
  assign lock_exit  = !i_p1_lock || !i_p1_req || starve_hit;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= FREE;
      r_last    <= 1'b1;
      r_starve  <= '0;
      r_rd_pend <= 1'b0;
      r_rd_port <= 1'b0;
    end else begin
      r_rd_pend <= (p0_gnt && !i_p0_write) || (p1_gnt && !i_p1_write);
      r_rd_port <= p1_gnt;

      if (p0_gnt) begin
        r_last <= 1'b0;
      end else if (p1_gnt) begin
        r_last <= 1'b1;
      end

      case (r_state)
        FREE: begin
          if (p1_gnt && i_p1_lock) begin
            r_state  <= LOCKED;
            r_starve <= '0;
          end else if (p0_gnt) begin
            r_starve <= '0;
          end
        end
        LOCKED: begin
          if (lock_exit) begin
            r_state  <= FREE;
            r_starve <= '0;
            if (starve_hit) begin
              r_last <= 1'b1;
            end
          end else if (p1_gnt && i_p0_req) begin
            r_starve <= r_starve + SW'(1);
          end
        end
        default: r_state <= FREE;
      endcase
    end
  end

  assign o_p0_gnt  = p0_gnt;
  assign o_p1_gnt  = p1_gnt;
  assign o_tcm_sel = p0_gnt | p1_gnt;

  // Forward the granted port's access to the TCM; idle bus is driven to zero.
  always_comb begin
    o_tcm_addr  = '0;
    o_tcm_write = 1'b0;
    o_tcm_mask  = 4'd0;
    o_tcm_data  = 32'd0;
    if (p0_gnt) begin
      o_tcm_addr  = i_p0_addr;
      o_tcm_write = i_p0_write;
      o_tcm_mask  = i_p0_mask;
      o_tcm_data  = i_p0_data;
    end else if (p1_gnt) begin
      o_tcm_addr  = i_p1_addr;
      o_tcm_write = i_p1_write;
      o_tcm_mask  = i_p1_mask;
      o_tcm_data  = i_p1_data;
    end
  end

  // Read return is masked during reset so a read in flight is dropped silently.
  assign o_p0_rvalid = r_rd_pend && !r_rd_port && !i_reset;
  assign o_p1_rvalid = r_rd_pend &&  r_rd_port && !i_reset;
  assign o_p0_data   = o_p0_rvalid ? i_tcm_data : 32'd0;
  assign o_p1_data   = o_p1_rvalid ? i_tcm_data : 32'd0;

endmodule

// File: tb/tb_tcm_data_arb.sv
// Self-checking bench for tcm_data_arb: fixed expected grant sequences per scenario and a
// read scoreboard fed from a shadow memory, compared against a behavioural TCM.
module tb_tcm_data_arb;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_req, p0_write, p1_req, p1_write, p1_lock;
  logic [AW+1:2] p0_addr, p1_addr;
  logic [3:0]    p0_mask, p1_mask;
  logic [31:0]   p0_wdata, p1_wdata;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0]   p0_rdata, p1_rdata;
  logic          tcm_sel, tcm_write;
  logic [AW+1:2] tcm_addr;
  logic [3:0]    tcm_mask;
  logic [31:0]   tcm_wdata;
  logic [31:0]   tcm_rdata = 32'd0;

  logic [31:0] mem    [256];
  logic [31:0] shadow [256];

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          due;
  } rd_t;
  rd_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  tcm_data_arb #(.MEM_ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_p0_req(p0_req), .i_p0_addr(p0_addr), .i_p0_write(p0_write),
    .i_p0_mask(p0_mask), .i_p0_data(p0_wdata),
    .o_p0_gnt(p0_gnt), .o_p0_rvalid(p0_rvalid), .o_p0_data(p0_rdata),
    .i_p1_req(p1_req), .i_p1_addr(p1_addr), .i_p1_write(p1_write),
    .i_p1_mask(p1_mask), .i_p1_data(p1_wdata),
    .o_p1_gnt(p1_gnt), .o_p1_rvalid(p1_rvalid), .o_p1_data(p1_rdata),
    .i_p1_lock(p1_lock),
    .o_tcm_sel(tcm_sel), .o_tcm_addr(tcm_addr), .o_tcm_write(tcm_write),
    .o_tcm_mask(tcm_mask), .o_tcm_data(tcm_wdata), .i_tcm_data(tcm_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural TCM: byte-masked write at the edge, registered read data.
  always @(posedge clk) begin
    if (reset) begin
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h20] <= 32'h12345678;
      mem[8'h03] <= 32'h00000000;
    end else if (tcm_sel) begin
      if (tcm_write) begin
        for (int b = 0; b < 4; b++)
          if (tcm_mask[b]) mem[tcm_addr][b*8 +: 8] <= tcm_wdata[b*8 +: 8];
      end else begin
        tcm_rdata <= mem[tcm_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%08h expected 0x%08h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive0(input logic req, input logic wr, input logic [7:0] addr,
                        input logic [3:0] mask, input logic [31:0] data);
    p0_req = req; p0_write = wr; p0_addr = addr; p0_mask = mask; p0_wdata = data;
  endtask

  task automatic drive1(input logic req, input logic wr, input logic [7:0] addr,
                        input logic [3:0] mask, input logic [31:0] data);
    p1_req = req; p1_write = wr; p1_addr = addr; p1_mask = mask; p1_wdata = data;
  endtask

  // One clock cycle with the currently driven inputs; e0/e1 are the expected grants.
  task automatic step(input logic e0, input logic e1);
    logic          x0, x1;
    logic [31:0]   xd;
    logic [AW+1:2] xa;
    rd_t           ent;
    @(negedge clk);
    x0 = 1'b0; x1 = 1'b0; xd = 32'd0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      ent = sb.pop_front();
      if (!reset) begin
        x0 = ~ent.port;
        x1 = ent.port;
        xd = ent.data;
      end
    end
    xa = e0 ? p0_addr : (e1 ? p1_addr : '0);
    check("p0_gnt",    32'(p0_gnt),    32'(e0));
    check("p1_gnt",    32'(p1_gnt),    32'(e1));
    check("tcm_sel",   32'(tcm_sel),   32'(e0 | e1));
    check("tcm_addr",  32'(tcm_addr),  32'(xa));
    check("p0_rvalid", 32'(p0_rvalid), 32'(x0));
    check("p1_rvalid", 32'(p1_rvalid), 32'(x1));
    check("p0_rdata",  p0_rdata,       x0 ? xd : 32'd0);
    check("p1_rdata",  p1_rdata,       x1 ? xd : 32'd0);
    if (e0 && !p0_write) sb.push_back('{1'b0, shadow[p0_addr], cyc + 1});
    if (e1 && !p1_write) sb.push_back('{1'b1, shadow[p1_addr], cyc + 1});
    if (e0 && p0_write)
      for (int b = 0; b < 4; b++)
        if (p0_mask[b]) shadow[p0_addr][b*8 +: 8] = p0_wdata[b*8 +: 8];
    if (e1 && p1_write)
      for (int b = 0; b < 4; b++)
        if (p1_mask[b]) shadow[p1_addr][b*8 +: 8] = p1_wdata[b*8 +: 8];
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    shadow[8'h10] = 32'hDEADBEEF;
    shadow[8'h20] = 32'h12345678;
    shadow[8'h03] = 32'h00000000;
    reset = 1'b1;
    p1_lock = 1'b0;
    drive0(1'b0, 1'b0, 8'h00, 4'h0, 32'd0);
    drive1(1'b0, 1'b0, 8'h00, 4'h0, 32'd0);
    step(1'b0, 1'b0);
    drive0(1'b1, 1'b0, 8'h10, 4'h0, 32'd0);
    step(1'b0, 1'b0);                          // grant gated by reset

    // Single port-0 read
    reset = 1'b0;
    step(1'b1, 1'b0);
    drive0(1'b0, 1'b0, 8'h00, 4'h0, 32'd0);
    step(1'b0, 1'b0);

    // Contention from reset: p0 favoured first, then strict alternation
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    drive0(1'b1, 1'b0, 8'h10, 4'h0, 32'd0);
    drive1(1'b1, 1'b0, 8'h20, 4'h0, 32'd0);
    for (int i = 0; i < 6; i++) step(i % 2 == 0, i % 2 == 1);
    drive0(1'b0, 1'b0, 8'h00, 4'h0, 32'd0);
    drive1(1'b0, 1'b0, 8'h00, 4'h0, 32'd0);
    step(1'b0, 1'b0);

    // Masked write by p1, then read-after-write by p0
    drive1(1'b1, 1'b1, 8'h03, 4'b0101, 32'hAABBCCDD);
    step(1'b0, 1'b1);
    drive1(1'b0, 1'b0, 8'h00, 4'h0, 32'd0);
    drive0(1'b1, 1'b0, 8'h03, 4'h0, 32'd0);
    step(1'b1, 1'b0);
    drive0(1'b0, 1'b0, 8'h00, 4'h0, 32'd0);
    step(1'b0, 1'b0);
    check("raw_shadow", shadow[8'h03], 32'h00BB00DD);

    // Starvation: locked p1 gets 4 grants while p0 waits, then p0 once, then re-lock
    drive1(1'b1, 1'b0, 8'h20, 4'h0, 32'd0);
    p1_lock = 1'b1;
    step(1'b0, 1'b1);
    drive0(1'b1, 1'b0, 8'h10, 4'h0, 32'd0);
    repeat (4) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    drive1(1'b0, 1'b0, 8'h00, 4'h0, 32'd0);
    step(1'b0, 1'b0);                          // still locked: p0 refused
    step(1'b1, 1'b0);
    drive0(1'b0, 1'b0, 8'h00, 4'h0, 32'd0);
    p1_lock = 1'b0;
    step(1'b0, 1'b0);

    // Lock released after two grants
    drive1(1'b1, 1'b0, 8'h20, 4'h0, 32'd0);
    p1_lock = 1'b1;
    step(1'b0, 1'b1);
    drive0(1'b1, 1'b0, 8'h10, 4'h0, 32'd0);
    step(1'b0, 1'b1);
    p1_lock = 1'b0;
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    drive0(1'b0, 1'b0, 8'h00, 4'h0, 32'd0);
    step(1'b0, 1'b1);
    drive1(1'b0, 1'b0, 8'h00, 4'h0, 32'd0);
    step(1'b0, 1'b0);

    // Reset arriving the cycle after a p0 read grant
    drive0(1'b1, 1'b0, 8'h10, 4'h0, 32'd0);
    step(1'b1, 1'b0);
    drive0(1'b0, 1'b0, 8'h00, 4'h0, 32'd0);
    drive1(1'b1, 1'b0, 8'h20, 4'h0, 32'd0);
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    step(1'b0, 1'b1);
    drive1(1'b0, 1'b0, 8'h00, 4'h0, 32'd0);
    step(1'b0, 1'b0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
